// File: rtl/updown_counter_ctl.sv
// Purpose  : parametrised up/down counter with programmable limit, load, and
//            WRAP / SAT / ONESHOT / PINGPONG modes, registered tc pulse and done flag.
// Latency  : one cycle; count/tc/done/dir update on the clk edge that samples the tick or load.
// Backpress: none; the counter reacts to every qualified tick, and a load always wins over a tick.
//
// Ports:
//   clk, rst         clock (rising edge), asynchronous active-high reset
//   en               count enable (feeds the prescaler when it is built in)
//   select           direction request, 1=up; ignored in PINGPONG except on load
//   load, load_val   synchronous load; value is clamped to limit
//   limit            inclusive upper bound; lower bound is always 0
//   mode             00=WRAP 01=SAT 10=ONESHOT 11=PINGPONG
//   prediv           prescale divide-minus-one (only with COUNTER_PRESCALE_EN)
//   count, tc, done, dir   registered outputs
//
// Optional feature macro: COUNTER_PRESCALE_EN adds a PRE_BITS-wide prescaler and
// the prediv port; without it every enabled cycle is a tick.

module updown_counter_ctl #(
  parameter int BITS     = 8,
  parameter int PRE_BITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                select,
  input  logic                load,
  input  logic [BITS-1:0]     load_val,
  input  logic [BITS-1:0]     limit,
  input  logic [1:0]          mode,
`ifdef COUNTER_PRESCALE_EN
  input  logic [PRE_BITS-1:0] prediv,
`endif
  output logic [BITS-1:0]     count,
  output logic                tc,
  output logic                done,
  output logic                dir
);

  localparam logic [1:0] MODE_WRAP    = 2'b00;
  localparam logic [1:0] MODE_SAT     = 2'b01;
  localparam logic [1:0] MODE_ONESHOT = 2'b10;
  localparam logic [1:0] MODE_PP      = 2'b11;

  localparam logic [BITS-1:0] ONE = BITS'(1);

  if (BITS < 2 || BITS > 16 || PRE_BITS < 1) begin : g_param_check
    $error("updown_counter_ctl: BITS must be 2..16 and PRE_BITS at least 1");
  end

  logic [BITS-1:0] count_q, count_d;
  logic            tc_q, tc_d;
  logic            done_q, done_d;
  logic            dir_q, dir_d;
  logic            tick;

  // ------------------------------------------------------------------
  // Tick generation
  // ------------------------------------------------------------------
`ifdef COUNTER_PRESCALE_EN
  localparam logic [PRE_BITS-1:0] PRE_ONE = PRE_BITS'(1);

  logic [PRE_BITS-1:0] pre_q, pre_d;
  logic                pre_strobe;

  // The >= compare keeps the prescaler from running the long way round
  // if prediv is lowered below the current phase.
  always_comb begin
    pre_d      = pre_q;
    pre_strobe = 1'b0;
    if (load) begin
      pre_d = '0;
    end else if (en) begin
      if (pre_q >= prediv) begin
        pre_strobe = 1'b1;
        pre_d      = '0;
      end else begin
        pre_d = pre_q + PRE_ONE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end

  assign tick = pre_strobe;
`else
  assign tick = en;
`endif

  // ------------------------------------------------------------------
  // Shared step helpers
  // ------------------------------------------------------------------
  logic            at_top, at_bot, step_up;
  logic [BITS-1:0] cnt_inc, cnt_dec, dec_clamped, lim_m1, pp_low;
  logic [BITS-1:0] sat_cnt;
  logic            sat_tc;

  // ">=" so a limit lowered beneath the current count still counts as top.
  assign at_top  = (count_q >= limit);
  assign at_bot  = (count_q == '0);
  assign cnt_inc = count_q + ONE;
  assign cnt_dec = count_q - ONE;
  // A down step from above a freshly lowered limit lands on the limit.
  assign dec_clamped = (cnt_dec > limit) ? limit : cnt_dec;
  // Ping-pong reflection targets collapse to 0 when the range is empty.
  assign lim_m1  = (limit == '0) ? '0 : (limit - ONE);
  assign pp_low  = (limit == '0) ? '0 : ONE;
  assign step_up = (mode == MODE_PP) ? dir_q : select;

  // Saturating step, shared by SAT and ONESHOT. tc marks the landing tick only.
  always_comb begin
    sat_cnt = count_q;
    sat_tc  = 1'b0;
    if (step_up) begin
      if (at_top) begin
        sat_cnt = limit;
      end else begin
        sat_cnt = cnt_inc;
        sat_tc  = (cnt_inc == limit);
      end
    end else begin
      if (at_bot) begin
        sat_cnt = '0;
      end else begin
        sat_cnt = dec_clamped;
        sat_tc  = (dec_clamped == '0);
      end
    end
  end

  // ------------------------------------------------------------------
  // Next-state logic: load beats tick; done is sticky across mode changes
  // ------------------------------------------------------------------
  always_comb begin
    count_d = count_q;
    tc_d    = 1'b0;
    done_d  = done_q;
    dir_d   = (mode == MODE_PP) ? dir_q : select;

    if (load) begin
      count_d = (load_val > limit) ? limit : load_val;
      done_d  = 1'b0;
      dir_d   = select;
    end else if (tick) begin
      case (mode)
        MODE_WRAP: begin
          if (select) begin
            if (at_top) begin
              count_d = '0;
              tc_d    = 1'b1;
            end else begin
              count_d = cnt_inc;
            end
          end else begin
            if (at_bot) begin
              count_d = limit;
              tc_d    = 1'b1;
            end else begin
              count_d = dec_clamped;
            end
          end
        end
        MODE_SAT: begin
          count_d = sat_cnt;
          tc_d    = sat_tc;
        end
        MODE_ONESHOT: begin
          if (done_q) begin
            // Finished: hold, but never sit above a lowered limit.
            count_d = at_top ? limit : count_q;
          end else begin
            count_d = sat_cnt;
            tc_d    = sat_tc;
            done_d  = sat_tc;
          end
        end
        MODE_PP: begin
          if (dir_q && at_top) begin
            count_d = lim_m1;
            dir_d   = 1'b0;
            tc_d    = 1'b1;
          end else if (!dir_q && at_bot) begin
            count_d = pp_low;
            dir_d   = 1'b1;
            tc_d    = 1'b1;
          end else begin
            count_d = dir_q ? cnt_inc : dec_clamped;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      tc_q    <= 1'b0;
      done_q  <= 1'b0;
      dir_q   <= 1'b1;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
      done_q  <= done_d;
      dir_q   <= dir_d;
    end
  end

  assign count = count_q;
  assign tc    = tc_q;
  assign done  = done_q;
  assign dir   = dir_q;

endmodule

// File: tb/tb_updown_counter_ctl.sv
module tb_updown_counter_ctl;

  localparam int BITS     = 4;
  localparam int PRE_BITS = 4;

  localparam int M_WRAP = 0;
  localparam int M_SAT  = 1;
  localparam int M_OS   = 2;
  localparam int M_PP   = 3;

  logic                clk = 1'b0;
  logic                rst;
  logic                en;
  logic                select;
  logic                load;
  logic [BITS-1:0]     load_val;
  logic [BITS-1:0]     limit;
  logic [1:0]          mode;
`ifdef COUNTER_PRESCALE_EN
  logic [PRE_BITS-1:0] prediv;
`endif
  logic [BITS-1:0]     count;
  logic                tc;
  logic                done;
  logic                dir;

  always #5 clk = ~clk;

  updown_counter_ctl #(.BITS(BITS), .PRE_BITS(PRE_BITS)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .select   (select),
    .load     (load),
    .load_val (load_val),
    .limit    (limit),
    .mode     (mode),
`ifdef COUNTER_PRESCALE_EN
    .prediv   (prediv),
`endif
    .count    (count),
    .tc       (tc),
    .done     (done),
    .dir      (dir)
  );

  typedef struct {
    string           nm;
    logic            en;
    logic            sel;
    logic            ld;
    logic [BITS-1:0] lv;
    logic [BITS-1:0] lim;
    logic [1:0]      md;
    logic [3:0]      pd;
    logic [BITS-1:0] ec;
    logic            etc;
    logic            ed;
    logic            edir;
  } vec_t;

  typedef struct {
    string           nm;
    logic [BITS-1:0] count;
    logic            tc;
    logic            done;
    logic            dir;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  int pp_c [8] = '{1, 2, 3, 2, 1, 0, 1, 2};
  bit pp_t [8] = '{0, 0, 0, 1, 0, 0, 1, 0};
  bit pp_d [8] = '{1, 1, 1, 0, 0, 0, 1, 1};
  int ps_c [11] = '{0, 0, 1, 1, 1, 1, 1, 1, 1, 2, 2};
  bit ps_e [11] = '{1, 1, 1, 1, 0, 0, 0, 0, 1, 1, 1};

  function automatic void add(string nm, bit e, bit s, bit l, int lv, int lim, int md,
                              int ec, bit t, bit d, bit dr, int pd = 0);
    vec_t v;
    v.nm   = nm;
    v.en   = e;
    v.sel  = s;
    v.ld   = l;
    v.lv   = BITS'(lv);
    v.lim  = BITS'(lim);
    v.md   = 2'(md);
    v.pd   = 4'(pd);
    v.ec   = BITS'(ec);
    v.etc  = t;
    v.ed   = d;
    v.edir = dr;
    vecs.push_back(v);
  endfunction

  function automatic void expect_out(string nm, int c, bit t, bit d, bit dr);
    exp_t x;
    x.nm    = nm;
    x.count = BITS'(c);
    x.tc    = t;
    x.done  = d;
    x.dir   = dr;
    sb.push_back(x);
  endfunction

  task automatic check_out();
    exp_t x;
    if (sb.size() == 0) begin
      errors++;
      checks++;
      $display("FAIL scoreboard_empty: nothing expected at t=%0t", $time);
    end else begin
      x = sb.pop_front();
      checks++;
      if (count !== x.count || tc !== x.tc || done !== x.done || dir !== x.dir) begin
        errors++;
        $display("FAIL %s: got count=%0d tc=%b done=%b dir=%b, want count=%0d tc=%b done=%b dir=%b",
                 x.nm, count, tc, done, dir, x.count, x.tc, x.done, x.dir);
      end
    end
  endtask

  task automatic apply(vec_t v);
    en       = v.en;
    select   = v.sel;
    load     = v.ld;
    load_val = v.lv;
    limit    = v.lim;
    mode     = v.md;
`ifdef COUNTER_PRESCALE_EN
    prediv   = v.pd;
`endif
    expect_out(v.nm, int'(v.ec), v.etc, v.ed, v.edir);
    @(posedge clk);
    #1;
    check_out();
  endtask

  initial begin
    // ---------------- vector table ----------------
    // WRAP up, limit 9: tc on every return to 0
    for (int i = 1; i <= 20; i++)
      add("wrap_up", 1, 1, 0, 0, 9, M_WRAP, i % 10, (i % 10) == 0, 0, 1);
    add("wrap_en_low", 0, 1, 0, 0, 9, M_WRAP, 0, 0, 0, 1);
    // WRAP down from 0 wraps to limit
    add("wrap_dn_bot", 1, 0, 0, 0, 9, M_WRAP, 9, 1, 0, 0);
    add("wrap_dn",     1, 0, 0, 0, 9, M_WRAP, 8, 0, 0, 0);
    // SAT down from 3
    add("sat_load",    1, 0, 1, 3, 9, M_SAT, 3, 0, 0, 0);
    add("sat_dn",      1, 0, 0, 0, 9, M_SAT, 2, 0, 0, 0);
    add("sat_dn",      1, 0, 0, 0, 9, M_SAT, 1, 0, 0, 0);
    add("sat_dn_land", 1, 0, 0, 0, 9, M_SAT, 0, 1, 0, 0);
    for (int i = 0; i < 5; i++)
      add("sat_dn_hold", 1, 0, 0, 0, 9, M_SAT, 0, 0, 0, 0);
    // SAT up to limit 2, then limit lowered under the count
    add("sat_up",      1, 1, 0, 0, 2, M_SAT, 1, 0, 0, 1);
    add("sat_up_land", 1, 1, 0, 0, 2, M_SAT, 2, 1, 0, 1);
    add("sat_up_hold", 1, 1, 0, 0, 2, M_SAT, 2, 0, 0, 1);
    add("sat_lim_low", 1, 1, 0, 0, 1, M_SAT, 1, 0, 0, 1);
    add("sat_en_low",  0, 1, 0, 0, 1, M_SAT, 1, 0, 0, 1);
    // ONESHOT to 5, sticky done across a mode change, reload clears done
    add("os_load", 1, 1, 1, 0, 5, M_OS, 0, 0, 0, 1);
    for (int i = 1; i <= 5; i++)
      add("os_up", 1, 1, 0, 0, 5, M_OS, i, i == 5, i == 5, 1);
    for (int i = 0; i < 3; i++)
      add("os_hold", 1, 1, 0, 0, 5, M_OS, 5, 0, 1, 1);
    add("os_leave",  1, 1, 0, 0, 5, M_WRAP, 0, 1, 1, 1);
    add("os_reload", 1, 1, 1, 2, 5, M_OS, 2, 0, 0, 1);
    add("os_up2",    1, 1, 0, 0, 5, M_OS, 3, 0, 0, 1);
    add("os_up2",    1, 1, 0, 0, 5, M_OS, 4, 0, 0, 1);
    add("os_land2",  1, 1, 0, 0, 5, M_OS, 5, 1, 1, 1);
    // load + en together: load wins, value clamped, done cleared
    add("load_clamp", 1, 1, 1, 12, 9, M_WRAP, 9, 0, 0, 1);
    add("clamp_wrap", 1, 1, 0, 0,  9, M_WRAP, 0, 1, 0, 1);
    // PINGPONG limit 3, select driven low to show it is ignored
    add("pp_load", 1, 1, 1, 0, 3, M_PP, 0, 0, 0, 1);
    for (int i = 0; i < 8; i++)
      add("pp_step", 1, 0, 0, 0, 3, M_PP, pp_c[i], pp_t[i], 0, pp_d[i]);
    // limit 0: count pinned at 0, tc every tick in WRAP and PINGPONG
    add("lim0_load", 1, 1, 1, 5, 0, M_WRAP, 0, 0, 0, 1);
    add("lim0_wrap", 1, 1, 0, 0, 0, M_WRAP, 0, 1, 0, 1);
    add("lim0_wrap", 1, 1, 0, 0, 0, M_WRAP, 0, 1, 0, 1);
    add("lim0_pp",   1, 1, 0, 0, 0, M_PP,   0, 1, 0, 0);
    add("lim0_pp",   1, 1, 0, 0, 0, M_PP,   0, 1, 0, 1);
`ifdef COUNTER_PRESCALE_EN
    // prediv=2: one step per three enabled cycles; en low freezes the phase
    add("ps_load", 1, 1, 1, 0, 15, M_WRAP, 0, 0, 0, 1, 2);
    for (int i = 0; i < 11; i++)
      add("ps_step", ps_e[i], 1, 0, 0, 15, M_WRAP, ps_c[i], 0, 0, 1, 2);
`endif
    // setup for the asynchronous reset: done set, dir driven low
    add("ar_load", 1, 1, 1, 0, 5, M_OS, 0, 0, 0, 1);
    for (int i = 1; i <= 5; i++)
      add("ar_up", 1, 1, 0, 0, 5, M_OS, i, i == 5, i == 5, 1);
    add("ar_pp", 1, 1, 0, 0, 5, M_PP, 4, 1, 1, 0);

    // ---------------- reset ----------------
    rst      = 1'b1;
    en       = 1'b0;
    select   = 1'b0;
    load     = 1'b0;
    load_val = '0;
    limit    = '0;
    mode     = '0;
`ifdef COUNTER_PRESCALE_EN
    prediv   = '0;
`endif
    expect_out("reset", 0, 0, 0, 1);
    @(posedge clk);
    #1;
    check_out();
    rst = 1'b0;

    foreach (vecs[i]) apply(vecs[i]);

    // ---------------- asynchronous reset mid-count ----------------
    #3;
    rst = 1'b1;
    #1;
    expect_out("async_rst", 0, 0, 0, 1);
    check_out();
    @(negedge clk);
    rst      = 1'b0;
    en       = 1'b1;
    select   = 1'b1;
    load     = 1'b0;
    limit    = BITS'(9);
    mode     = 2'(M_WRAP);
`ifdef COUNTER_PRESCALE_EN
    prediv   = '0;
`endif
    expect_out("after_rst", 1, 0, 0, 1);
    @(posedge clk);
    #1;
    check_out();

    if (sb.size() != 0) begin
      errors++;
      checks++;
      $display("FAIL scoreboard_leftover: %0d entries never compared", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
